divider_4bit_seq: RTL and testbench

Sequential unsigned restoring divider: accepts a dividend and divisor on a one-cycle start strobe and performs one shift-subtract-restore step per clock. It presents quotient and remainder with a one-cycle done pulse. It is the inverse-operation companion to the combinational add/subtract datapath: it consumes the subtract path iteratively instead of in a single pass. It sits beside the arithmetic blocks as a multi-cycle functional unit with a start/done handshake.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 26 ++
 rtl/divider_4bit_seq.sv | 117 +++++++++++
 tb/tb_divider_4bit_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 4;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, restore on borrow.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] r_out,
    output logic             q_bit,
    output logic             borrow
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] s;

    always_comb begin
        t      = {r_in, q_msb};
        s      = t - {1'b0, d_in};
        borrow = s[WIDTH];
        q_bit  = ~s[WIDTH];
        r_out  = s[WIDTH] ? t[WIDTH-1:0] : s[WIDTH-1:0];
    end

endmodule

// File: rtl/divider_4bit_seq.sv
// Sequential unsigned restoring divider with start/done handshake, one step per clock.
module divider_4bit_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_r;
    logic             step_qbit;
    logic             step_borrow;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_in   (r_q),
        .q_msb  (q_q[WIDTH-1]),
        .d_in   (d_q),
        .r_out  (step_r),
        .q_bit  (step_qbit),
        .borrow (step_borrow)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                // DONE accepts a new request just like IDLE for back-to-back use
                if (start) begin
                    q_d     = dividend;
                    r_d     = '0;
                    d_d     = divisor;
                    count_d = '0;
                    dbz_d   = (divisor == '0);
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                q_d     = {q_q[WIDTH-2:0], step_qbit};
                r_d     = step_r;
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    quot_d  = {q_q[WIDTH-2:0], step_qbit};
                    rem_d   = step_r;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Quotient bit and borrow are complementary views of the same trial subtraction
    always_ff @(posedge clk) begin
        if (!rst && state_q == CALC) begin
            assert (step_qbit == !step_borrow);
        end
    end

    assign busy        = (state_q == CALC);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_4bit_seq.sv
// Directed-vector bench for the sequential restoring divider, plus an exhaustive 4-bit sweep.
module tb_divider_4bit_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;

    divider_4bit_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dbz;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Drive a request and take the accepting edge; operands are scrambled afterwards
    task automatic start_op(input int a, input int b);
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        tick();
        start    = 1'b0;
        dividend = W'(a) ^ 4'hA;
        divisor  = W'(b) ^ 4'h5;
    endtask

    // Counts edges from the accepting edge until done, and busy cycles seen on the way
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt, eq, er;

        vecs[0] = '{a: 13, b: 3,  q: 4,  r: 1, dbz: 0};
        vecs[1] = '{a: 15, b: 1,  q: 15, r: 0, dbz: 0};
        vecs[2] = '{a: 5,  b: 7,  q: 0,  r: 5, dbz: 0};
        vecs[3] = '{a: 0,  b: 9,  q: 0,  r: 0, dbz: 0};
        vecs[4] = '{a: 15, b: 15, q: 1,  r: 0, dbz: 0};
        vecs[5] = '{a: 9,  b: 0,  q: 15, r: 9, dbz: 1};
        vecs[6] = '{a: 8,  b: 2,  q: 4,  r: 0, dbz: 0};

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        tick();
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_q", int'(quotient), 0);
        chk("rst_r", int'(remainder), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        rst = 1'b0;

        // Directed table, each op separated by one idle cycle after done
        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_done(lat, bcnt);
            chk($sformatf("vec%0d_lat", i), lat, W);
            chk($sformatf("vec%0d_busy", i), bcnt, W);
            chk($sformatf("vec%0d_q", i), int'(quotient), vecs[i].q);
            chk($sformatf("vec%0d_r", i), int'(remainder), vecs[i].r);
            chk($sformatf("vec%0d_dbz", i), int'(div_by_zero), vecs[i].dbz);
            tick();
            chk($sformatf("vec%0d_done_pulse", i), int'(done), 0);
            chk($sformatf("vec%0d_q_hold", i), int'(quotient), vecs[i].q);
        end

        // start during busy is ignored; start during done is accepted
        start_op(14, 4);
        tick();
        start = 1'b1; dividend = 4'd6; divisor = 4'd2;
        tick();
        start = 1'b0;
        chk("ign_busy", int'(busy), 1);
        wait_done(lat, bcnt);
        chk("ign_lat", lat, 2);
        chk("ign_q", int'(quotient), 3);
        chk("ign_r", int'(remainder), 2);
        start_op(12, 5);
        chk("b2b_busy", int'(busy), 1);
        chk("b2b_q_hold", int'(quotient), 3);
        wait_done(lat, bcnt);
        chk("b2b_lat", lat, W);
        chk("b2b_q", int'(quotient), 2);
        chk("b2b_r", int'(remainder), 2);
        tick();

        // Reset on the third CALC cycle aborts without a done pulse
        start_op(11, 3);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_q", int'(quotient), 0);
        chk("abort_r", int'(remainder), 0);
        chk("abort_dbz", int'(div_by_zero), 0);
        start_op(11, 3);
        wait_done(lat, bcnt);
        chk("post_rst_lat", lat, W);
        chk("post_rst_q", int'(quotient), 3);
        chk("post_rst_r", int'(remainder), 2);

        // Exhaustive sweep, issued back-to-back from each done cycle
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                eq = (b == 0) ? 15 : a / b;
                er = (b == 0) ? a  : a % b;
                start_op(a, b);
                wait_done(lat, bcnt);
                chk($sformatf("sw_%0d_%0d_lat", a, b), lat, W);
                chk($sformatf("sw_%0d_%0d_q", a, b), int'(quotient), eq);
                chk($sformatf("sw_%0d_%0d_r", a, b), int'(remainder), er);
                chk($sformatf("sw_%0d_%0d_dbz", a, b), int'(div_by_zero), (b == 0) ? 1 : 0);
                if (b != 0) begin
                    chk($sformatf("sw_%0d_%0d_sum", a, b), int'(quotient) * b + int'(remainder), a);
                    chk($sformatf("sw_%0d_%0d_rlt", a, b), int'(int'(remainder) < b), 1);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
